// File: rtl/tagged_memory.sv
// Tagged main memory model on a multiplexed address/data bus: a strobe latches the
// word address, reads return {tag, data} one clock later, writes commit at the edge.
module tagged_memory #(
  parameter int AW = 20,
  parameter int DW = 64,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_ad,
  input  logic [TW-1:0] i_tag,
  input  logic          i_astb,
  input  logic          i_atomic,
  input  logic          i_rd,
  input  logic          i_wr,
  output logic [DW-1:0] o_data,
  output logic [TW-1:0] o_tag
);

  localparam int WW    = TW + DW;
  localparam int DEPTH = 2 ** AW;

  logic [WW-1:0] mem [DEPTH];
  logic [AW-1:0] waddr;
  logic [AW-1:0] ea;
  logic [WW-1:0] wr_word;

  // The atomic flag only marks the RMW pair; addressing already reuses waddr.
  logic unused_atomic;
  assign unused_atomic = i_atomic;

  // A strobe in the same cycle as an access addresses it directly.
  assign ea      = i_astb ? i_ad[AW-1:0] : waddr;
  assign wr_word = {i_tag, i_ad};

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr  <= '0;
      o_data <= '0;
      o_tag  <= '0;
    end else begin
      if (i_astb) begin
        waddr <= i_ad[AW-1:0];
      end
      if (i_rd) begin
        // Read during a write returns the word being written.
        {o_tag, o_data} <= i_wr ? wr_word : mem[ea];
      end
    end
  end

  // Storage is never cleared by reset; accesses during reset are dropped.
  always_ff @(posedge clk) begin
    if (!reset && i_wr) begin
      mem[ea] <= wr_word;
    end
  end

endmodule

// File: tb/tb_tagged_memory.sv
// Self-checking bench for tagged_memory: a reference model predicts every read,
// predictions are queued at issue and compared one clock later by a monitor.
module tb_tagged_memory;

  localparam int AW = 20;
  localparam int DW = 64;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] i_ad = '0;
  logic [TW-1:0] i_tag = '0;
  logic          i_astb = 1'b0;
  logic          i_atomic = 1'b0;
  logic          i_rd = 1'b0;
  logic          i_wr = 1'b0;
  logic [DW-1:0] o_data;
  logic [TW-1:0] o_tag;

  int checks = 0;
  int errors = 0;

  logic [TW+DW-1:0] model [logic [AW-1:0]];
  logic [AW-1:0]    m_waddr = '0;
  logic [TW+DW-1:0] sb [$];

  logic             mon_rd;
  logic [TW+DW-1:0] mon_exp;

  tagged_memory #(.AW(AW), .DW(DW), .TW(TW)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_ad     (i_ad),
    .i_tag    (i_tag),
    .i_astb   (i_astb),
    .i_atomic (i_atomic),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .o_data   (o_data),
    .o_tag    (o_tag)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted read is compared one edge later.
  always @(posedge clk) begin
    mon_rd = i_rd && !reset;
    #1;
    if (mon_rd) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: read data %h/%h arrived with no prediction", o_tag, o_data);
      end else begin
        mon_exp = sb.pop_front();
        if ({o_tag, o_data} !== mon_exp) begin
          errors++;
          $display("FAIL read_data: got tag=%h data=%h, expected tag=%h data=%h",
                   o_tag, o_data, mon_exp[TW+DW-1:DW], mon_exp[DW-1:0]);
        end
      end
    end
  end

  function automatic logic [TW+DW-1:0] model_get(input logic [AW-1:0] a);
    return model.exists(a) ? model[a] : '0;
  endfunction

  // One bus cycle; the model is updated and any read prediction queued.
  task automatic drive(input logic astb, input logic [DW-1:0] ad, input logic [TW-1:0] tag,
                       input logic rd, input logic wr, input logic atomic);
    logic [AW-1:0] a;
    i_astb = astb; i_ad = ad; i_tag = tag; i_rd = rd; i_wr = wr; i_atomic = atomic;
    a = astb ? ad[AW-1:0] : m_waddr;
    if (!reset) begin
      if (wr) model[a] = {tag, ad};
      if (rd) sb.push_back(model_get(a));
      if (astb) m_waddr = ad[AW-1:0];
    end
    @(posedge clk); #1;
    i_astb = 1'b0; i_ad = '0; i_tag = '0; i_rd = 1'b0; i_wr = 1'b0; i_atomic = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 64'hABC, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h1111_2222_3333_4444, 8'h5A, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    m_waddr = '0;
    drive(1'b0, 64'h9999_9999_9999_9999, 8'hEE, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if (o_data !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%h, expected 00/0000000000000000", o_tag, o_data);
    end
    checks++;
    if (dut.waddr !== '0) begin
      errors++;
      $display("FAIL reset_waddr: got %h, expected 00000", dut.waddr);
    end
    drive(1'b1, 64'hABC, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_basic();
    drive(1'b1, 64'h12345, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut.waddr !== 20'h12345) begin
      errors++;
      $display("FAIL strobe_waddr: got %h, expected 12345", dut.waddr);
    end
    drive(1'b0, 64'hDEADBEEF_01234567, 8'h3C, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_data !== 64'hDEADBEEF_01234567 || o_tag !== 8'h3C) begin
      errors++;
      $display("FAIL basic_read: got %h/%h, expected 3c/deadbeef01234567", o_tag, o_data);
    end
  endtask

  task automatic test_truncation();
    drive(1'b1, 64'hFFFF_FFFF_FFF0_0007, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut.waddr !== 20'h00007) begin
      errors++;
      $display("FAIL trunc_waddr: got %h, expected 00007", dut.waddr);
    end
    drive(1'b0, 64'h55, 8'h01, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 64'h7, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_data !== 64'h55 || o_tag !== 8'h01) begin
      errors++;
      $display("FAIL trunc_read: got %h/%h, expected 01/0000000000000055", o_tag, o_data);
    end
  endtask

  task automatic test_rmw();
    drive(1'b1, 64'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 64'hAAAA, 8'h02, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (o_data !== 64'hAAAA || o_tag !== 8'h02) begin
      errors++;
      $display("FAIL rmw_read: got %h/%h, expected 02/000000000000aaaa", o_tag, o_data);
    end
  endtask

  task automatic test_rd_wr_same_cycle();
    drive(1'b1, 64'h200, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h77, 8'h05, 1'b1, 1'b1, 1'b0);
    checks++;
    if (o_data !== 64'h77 || o_tag !== 8'h05) begin
      errors++;
      $display("FAIL write_through: got %h/%h, expected 05/0000000000000077", o_tag, o_data);
    end
    drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'hDEAD_0000, 8'h44, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_hold();
    drive(1'b1, 64'h3_0000, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h300, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'h99, 8'h09, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'h98, 8'h08, 1'b0, 1'b1, 1'b0);
    checks++;
    if (o_data !== '0 || o_tag !== '0) begin
      errors++;
      $display("FAIL hold_outputs: got %h/%h, expected 00/0000000000000000", o_tag, o_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 15)) + 20'h4_0000;
      drive(1'b1, {44'h0, a}, 8'h00, 1'b0, 1'b0, 1'b0);
      drive(1'b0, {$urandom, $urandom}, 8'($urandom), 1'($urandom), 1'b1, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 15)) + 20'h4_0000;
      drive(1'b1, {44'hF0F0_F0F0_F0F, a}, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 64'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    reset = 1'b0;
    test_reset();
    test_basic();
    test_truncation();
    test_rmw();
    test_rd_wr_same_cycle();
    test_hold();
    test_back_to_back();
    @(posedge clk); #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d predictions left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
